// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants and types for the coprocessor-0 unit.
package cp0_pkg;

   // CP0 register indices
   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;

   // ExcCode values
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_BREAK   = 5'd9;
   localparam logic [4:0] EXC_TEQ     = 5'd13;

   // Cause field positions
   localparam int unsigned CAUSE_EXC_LSB   = 2;
   localparam int unsigned CAUSE_EXC_MSB   = 6;
   localparam int unsigned CAUSE_IP_LSB    = 8;
   localparam int unsigned CAUSE_IP_MSB    = 15;
   localparam int unsigned CAUSE_IP_SW_MSB = 9;
   localparam int unsigned CAUSE_IP_HW_LSB = 10;
   localparam int unsigned CAUSE_IP_TIMER  = 15;

   // Command selected for this cycle after priority resolution
   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_EXC,
      CMD_RET,
      CMD_WR
   } cp0_cmd_e;

endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: mfc0/mtc0/exception/eret bus between decode/execute and CP0.
interface cp0_unit_if;
   logic        we;
   logic        re;
   logic        exc_w;
   logic        ret_w;
   logic [4:0]  Rd;
   logic [4:0]  Wd;
   logic [4:0]  cause;
   logic [31:0] wdata;
   logic [31:0] pc_in;
   logic [31:0] rdata;
   logic [31:0] pcreg;
   logic [31:0] status;

   modport master (
      output we, re, exc_w, ret_w, Rd, Wd, cause, wdata, pc_in,
      input  rdata, pcreg, status
   );

   modport slave (
      input  we, re, exc_w, ret_w, Rd, Wd, cause, wdata, pc_in,
      output rdata, pcreg, status
   );
endinterface

// File: rtl/cp0_status_stack.sv
// cp0_status_stack: circular LIFO of saved Status words; a push when full
// overwrites the oldest entry so the most recent DEPTH levels survive.
module cp0_status_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp_q;
   logic [CW-1:0]    cnt_q;
   logic [PW-1:0]    top;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? LAST : p - PW'(1);
   endfunction

   assign top   = ptr_dec(wp_q);
   assign dout  = mem[top];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));

   // Write pointer and fill count; when full, wp_q already points at the oldest slot
   always_ff @(posedge clk) begin
      if (!rst) begin
         wp_q  <= '0;
         cnt_q <= '0;
      end else if (push) begin
         wp_q <= ptr_inc(wp_q);
         if (!full) cnt_q <= cnt_q + CW'(1);
      end else if (pop && !empty) begin
         wp_q  <= top;
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // Storage write, no reset needed since the count gates validity
   always_ff @(posedge clk) begin
      if (rst && push) mem[wp_q] <= din;
   end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: Count/Compare timer, Status with nesting stack, Cause, EPC and
// interrupt request generation for the MIPS CPU.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter int          STACK_DEPTH = 4,
   parameter int          NUM_HWIRQ   = 5,
   parameter logic [31:0] STATUS_RST  = 32'h0000_0701
) (
   input  logic                 clk,
   input  logic                 rst,
   cp0_unit_if.slave            bus,
   input  logic [NUM_HWIRQ-1:0] hw_irq,
   output logic                 irq_req,
   output logic                 stk_ovf,
   output logic                 stk_unf
);

   logic [31:0]          count_q, compare_q, status_q, epc_q;
   logic [4:0]           exc_code_q;
   logic [1:0]           ip_sw_q;
   logic                 ip_timer_q;
   logic [NUM_HWIRQ-1:0] hw_q;
   logic [31:0]          cause_val;
   logic [31:0]          stk_dout;
   logic                 stk_empty, stk_full;
   cp0_cmd_e             cmd;
   logic                 wr_count, wr_compare;

   // Resolve exc_w > ret_w > we into a single command
   always_comb begin
      cmd = CMD_NONE;
      if (bus.exc_w)      cmd = CMD_EXC;
      else if (bus.ret_w) cmd = CMD_RET;
      else if (bus.we)    cmd = CMD_WR;
   end

   assign wr_count   = (cmd == CMD_WR) && (bus.Wd == CP0_COUNT);
   assign wr_compare = (cmd == CMD_WR) && (bus.Wd == CP0_COMPARE);

   cp0_status_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (32)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd == CMD_EXC),
      .pop   (cmd == CMD_RET),
      .din   (status_q),
      .dout  (stk_dout),
      .empty (stk_empty),
      .full  (stk_full)
   );

   // Assemble Cause from its live fields
   always_comb begin
      cause_val = '0;
      cause_val[CAUSE_IP_TIMER]                       = ip_timer_q;
      cause_val[CAUSE_IP_HW_LSB +: NUM_HWIRQ]         = hw_q;
      cause_val[CAUSE_IP_SW_MSB:CAUSE_IP_LSB]         = ip_sw_q;
      cause_val[CAUSE_EXC_MSB:CAUSE_EXC_LSB]          = exc_code_q;
   end

   // mfc0 read mux
   always_comb begin
      bus.rdata = '0;
      if (bus.re) begin
         case (bus.Rd)
            CP0_COUNT:   bus.rdata = count_q;
            CP0_COMPARE: bus.rdata = compare_q;
            CP0_STATUS:  bus.rdata = status_q;
            CP0_CAUSE:   bus.rdata = cause_val;
            CP0_EPC:     bus.rdata = epc_q;
            default:     bus.rdata = '0;
         endcase
      end
   end

   assign bus.pcreg  = epc_q;
   assign bus.status = status_q;
   assign irq_req    = status_q[0] &
                       (|(cause_val[CAUSE_IP_MSB:CAUSE_IP_LSB] & status_q[15:8]));

   // Timer, compare-match latch and hw_irq sampling
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q    <= '0;
         compare_q  <= '0;
         ip_timer_q <= 1'b0;
         hw_q       <= '0;
      end else begin
         count_q <= wr_count ? bus.wdata : count_q + 32'd1;
         if (wr_compare) compare_q <= bus.wdata;
         if (wr_compare)                  ip_timer_q <= 1'b0;
         else if (count_q == compare_q)   ip_timer_q <= 1'b1;
         hw_q <= hw_irq;
      end
   end

   // Status, Cause, EPC and sticky stack flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         status_q   <= STATUS_RST;
         epc_q      <= '0;
         exc_code_q <= '0;
         ip_sw_q    <= '0;
         stk_ovf    <= 1'b0;
         stk_unf    <= 1'b0;
      end else begin
         case (cmd)
            CMD_EXC: begin
               status_q   <= {status_q[26:0], 5'b0};
               exc_code_q <= bus.cause;
               epc_q      <= bus.pc_in;
               if (stk_full) stk_ovf <= 1'b1;
            end
            CMD_RET: begin
               if (stk_empty) begin
                  status_q <= STATUS_RST;
                  stk_unf  <= 1'b1;
               end else begin
                  status_q <= stk_dout;
               end
            end
            CMD_WR: begin
               case (bus.Wd)
                  CP0_STATUS: status_q <= bus.wdata;
                  CP0_EPC:    epc_q    <= bus.wdata;
                  CP0_CAUSE:  ip_sw_q  <= bus.wdata[CAUSE_IP_SW_MSB:CAUSE_IP_LSB];
                  default:    ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed stimulus with a queue-based behavioural CP0 model
// checked every cycle, plus hand-computed literal expectations.
module tb_cp0_unit;
   import cp0_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] SRST  = 32'h0000_0701;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] hw_irq;
   logic       irq_req, stk_ovf, stk_unf;

   cp0_unit_if bus();

   cp0_unit #(
      .STACK_DEPTH (DEPTH),
      .NUM_HWIRQ   (5),
      .STATUS_RST  (SRST)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .hw_irq  (hw_irq),
      .irq_req (irq_req),
      .stk_ovf (stk_ovf),
      .stk_unf (stk_unf)
   );

   always #20 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        started = 1'b0;
   logic [31:0] m_count, m_compare, m_status, m_epc;
   logic [4:0]  m_exc, m_hw;
   logic [1:0]  m_sw;
   logic        m_ip7, m_ovf, m_unf;
   logic [31:0] m_stk[$];

   function automatic logic [31:0] m_cause();
      logic [31:0] c;
      c = '0;
      c[15] = m_ip7;
      for (int i = 0; i < 5; i++) c[10+i] = m_hw[i];
      c[9:8] = m_sw;
      c[6:2] = m_exc;
      return c;
   endfunction

   function automatic logic [31:0] m_rdata();
      if (!bus.re) return 32'h0;
      case (bus.Rd)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause();
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic m_irq();
      logic [31:0] c;
      c = m_cause();
      return m_status[0] & (|(c[15:8] & m_status[15:8]));
   endfunction

   // Model update on each rising edge from the stimulus in force
   always @(posedge clk) begin
      logic        wr;
      logic        t_n;
      logic [31:0] cnt_n;
      if (!rst) begin
         started   = 1'b1;
         m_count   = 0; m_compare = 0; m_status = SRST; m_epc = 0;
         m_exc     = 0; m_hw = 0; m_sw = 0; m_ip7 = 0; m_ovf = 0; m_unf = 0;
         m_stk.delete();
      end else begin
         wr    = bus.we && !bus.exc_w && !bus.ret_w;
         t_n   = (wr && bus.Wd == 5'd11) ? 1'b0 : (m_ip7 | (m_count == m_compare));
         cnt_n = (wr && bus.Wd == 5'd9) ? bus.wdata : m_count + 1;
         if (bus.exc_w) begin
            if (m_stk.size() == DEPTH) begin
               void'(m_stk.pop_front());
               m_ovf = 1'b1;
            end
            m_stk.push_back(m_status);
            m_status = m_status << 5;
            m_exc    = bus.cause;
            m_epc    = bus.pc_in;
         end else if (bus.ret_w) begin
            if (m_stk.size() == 0) begin
               m_status = SRST;
               m_unf    = 1'b1;
            end else begin
               m_status = m_stk.pop_back();
            end
         end else if (wr) begin
            case (bus.Wd)
               5'd11:   m_compare = bus.wdata;
               5'd12:   m_status  = bus.wdata;
               5'd13:   m_sw      = bus.wdata[9:8];
               5'd14:   m_epc     = bus.wdata;
               default: ;
            endcase
         end
         m_count = cnt_n;
         m_ip7   = t_n;
         m_hw    = hw_irq;
      end
   end

   // Compare DUT against the model on every falling edge
   always @(negedge clk) begin
      if (started) begin
         chk("rdata",   bus.rdata,      m_rdata());
         chk("status",  bus.status,     m_status);
         chk("pcreg",   bus.pcreg,      m_epc);
         chk("irq_req", {31'b0, irq_req}, {31'b0, m_irq()});
         chk("stk_ovf", {31'b0, stk_ovf}, {31'b0, m_ovf});
         chk("stk_unf", {31'b0, stk_unf}, {31'b0, m_unf});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      bus.we = 1'b0; bus.exc_w = 1'b0; bus.ret_w = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] idx, input logic [31:0] d);
      bus.we = 1'b1; bus.Wd = idx; bus.wdata = d;
      tick();
   endtask

   task automatic exc(input logic [4:0] c, input logic [31:0] pc);
      bus.exc_w = 1'b1; bus.cause = c; bus.pc_in = pc;
      tick();
   endtask

   task automatic eret();
      bus.ret_w = 1'b1;
      tick();
   endtask

   task automatic rchk(input logic [4:0] idx, input logic [31:0] exp, input string name);
      bus.re = 1'b1; bus.Rd = idx;
      #1;
      chk(name, bus.rdata, exp);
   endtask

   task automatic fchk(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b0; hw_irq = '0;
      bus.we = 0; bus.re = 0; bus.exc_w = 0; bus.ret_w = 0;
      bus.Rd = 0; bus.Wd = 0; bus.cause = 0; bus.wdata = 0; bus.pc_in = 0;
      tick(); tick();

      // reset state
      rchk(CP0_COUNT,   32'h0,   "rst_count");
      rchk(CP0_COMPARE, 32'h0,   "rst_compare");
      rchk(CP0_STATUS,  32'h701, "rst_status");
      rchk(CP0_CAUSE,   32'h0,   "rst_cause");
      rchk(CP0_EPC,     32'h0,   "rst_epc");
      fchk("rst_irq", irq_req, 1'b0);
      fchk("rst_ovf", stk_ovf, 1'b0);
      fchk("rst_unf", stk_unf, 1'b0);
      rst = 1'b1;

      // park Compare away from Count; the clear beats the 0==0 match
      mtc0(CP0_COMPARE, 32'hFFFF_0000);
      rchk(CP0_CAUSE, 32'h0, "cmp_clear_cause");

      // syscall and return
      exc(EXC_SYSCALL, 32'h0040_0010);
      rchk(CP0_CAUSE, 32'h20, "sys_cause");
      rchk(CP0_EPC, 32'h0040_0010, "sys_epc");
      chk("sys_status", bus.status, 32'h0000_E020);
      eret();
      chk("sys_ret_status", bus.status, 32'h701);

      // three nested exceptions
      exc(EXC_BREAK, 32'h0040_0100);
      chk("nest1", bus.status, 32'h0000_E020);
      rchk(CP0_CAUSE, 32'h24, "break_cause");
      exc(EXC_TEQ, 32'h0040_0200);
      chk("nest2", bus.status, 32'h001C_0400);
      rchk(CP0_CAUSE, 32'h34, "teq_cause");
      exc(EXC_SYSCALL, 32'h0040_0300);
      chk("nest3", bus.status, 32'h0380_8000);
      eret(); chk("unw1", bus.status, 32'h001C_0400);
      eret(); chk("unw2", bus.status, 32'h0000_E020);
      eret(); chk("unw3", bus.status, 32'h701);
      fchk("unw_unf", stk_unf, 1'b0);

      // five pushes into a depth-4 stack
      for (int i = 0; i < 4; i++) exc(EXC_SYSCALL, 32'h0040_1000 + 32'(i));
      fchk("ovf_before", stk_ovf, 1'b0);
      exc(EXC_SYSCALL, 32'h0040_2000);
      fchk("ovf_after", stk_ovf, 1'b1);
      chk("push5_status", bus.status, 32'h0200_0000);
      eret(); chk("pop1", bus.status, 32'h7010_0000);
      eret(); eret(); eret();
      chk("pop4", bus.status, 32'h0000_E020);
      fchk("pop4_unf", stk_unf, 1'b0);
      eret();
      chk("pop5_status", bus.status, 32'h701);
      fchk("pop5_unf", stk_unf, 1'b1);

      // timer match
      mtc0(CP0_STATUS, 32'h0000_8001);
      mtc0(CP0_COMPARE, 32'd20);
      mtc0(CP0_COUNT, 32'd10);
      rchk(CP0_COUNT, 32'd10, "tmr_count10");
      repeat (10) tick();
      rchk(CP0_COUNT, 32'd20, "tmr_count20");
      rchk(CP0_CAUSE, 32'h20, "tmr_not_yet");
      fchk("tmr_irq0", irq_req, 1'b0);
      tick();
      rchk(CP0_COUNT, 32'd21, "tmr_count21");
      rchk(CP0_CAUSE, 32'h8020, "tmr_ip7");
      fchk("tmr_irq1", irq_req, 1'b1);
      tick();
      rchk(CP0_CAUSE, 32'h8020, "tmr_sticky");
      mtc0(CP0_COMPARE, 32'h0000_1000);
      rchk(CP0_CAUSE, 32'h20, "tmr_cleared");
      fchk("tmr_irq_clr", irq_req, 1'b0);

      // Compare == 0 matches after Count wraps
      mtc0(CP0_COMPARE, 32'h0);
      mtc0(CP0_COUNT, 32'hFFFF_FFFE);
      tick();
      rchk(CP0_COUNT, 32'hFFFF_FFFF, "wrap_ff");
      tick();
      rchk(CP0_COUNT, 32'h0, "wrap_zero");
      rchk(CP0_CAUSE, 32'h20, "wrap_not_yet");
      tick();
      rchk(CP0_CAUSE, 32'h8020, "wrap_ip7");
      fchk("wrap_irq", irq_req, 1'b1);
      mtc0(CP0_COMPARE, 32'hFFFF_0000);

      // hardware interrupt line 0
      mtc0(CP0_STATUS, 32'h0000_0401);
      hw_irq = 5'b00001;
      rchk(CP0_CAUSE, 32'h20, "hw_delay");
      fchk("hw_irq0", irq_req, 1'b0);
      tick();
      rchk(CP0_CAUSE, 32'h420, "hw_set");
      fchk("hw_irq1", irq_req, 1'b1);
      hw_irq = 5'b00000;
      tick();
      rchk(CP0_CAUSE, 32'h20, "hw_clr");
      fchk("hw_irq_clr", irq_req, 1'b0);

      // exc_w, ret_w and we together: only the exception applies
      bus.exc_w = 1'b1; bus.ret_w = 1'b1; bus.we = 1'b1;
      bus.cause = EXC_TEQ; bus.pc_in = 32'h0040_0100;
      bus.Wd = CP0_EPC; bus.wdata = 32'h1234_5678;
      tick();
      chk("prio_status", bus.status, 32'h0000_8020);
      rchk(CP0_EPC, 32'h0040_0100, "prio_epc");
      rchk(CP0_CAUSE, 32'h34, "prio_cause");

      // software interrupt bits are the only writable Cause bits
      mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
      rchk(CP0_CAUSE, 32'h334, "sw_ip");
      fchk("sw_irq0", irq_req, 1'b0);
      mtc0(CP0_STATUS, 32'h0000_0201);
      fchk("sw_irq1", irq_req, 1'b1);

      // unimplemented index and read-enable gating
      mtc0(5'd5, 32'hAAAA_AAAA);
      rchk(5'd5, 32'h0, "unused_reg");
      bus.re = 1'b0; bus.Rd = CP0_STATUS;
      #1;
      chk("re_low", bus.rdata, 32'h0);

      // reset mid-nest empties the stack and clears flags
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rst2_status", bus.status, 32'h701);
      fchk("rst2_ovf", stk_ovf, 1'b0);
      fchk("rst2_unf", stk_unf, 1'b0);
      eret();
      chk("rst2_eret", bus.status, 32'h701);
      fchk("rst2_unf_set", stk_unf, 1'b1);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Parametrised coprocessor-0 unit for the 54-instruction MIPS CPU. It holds Count, Compare, Status, Cause and EPC, and saves Status on a configurable-depth stack so exceptions can nest. It samples external interrupt lines, runs the Count/Compare timer and raises a single interrupt request to the control unit. It sits beside the regfile; mfc0/mtc0, syscall/break/teq and eret drive it from the decode/execute stage.

## Interface
- STACK_DEPTH, 4 — number of saved Status entries (≥1).
- NUM_HWIRQ, 5 — external interrupt lines (1..5), mapped to Cause.IP[2+NUM_HWIRQ-1:2].
- STATUS_RST, 32'h0000_0701 — Status reset value.
- clk  in  1  — rising-edge clock.
- rst  in  1  — synchronous, active-low reset (0 = reset, sampled on clk).
- we  in  1  — mtc0 write strobe.
- re  in  1  — mfc0 read enable.
- exc_w  in  1  — exception entry strobe.
- ret_w  in  1  — eret strobe.
- Rd  in  5  — read register index.
- Wd  in  5  — write register index.
- cause  in  5  — ExcCode for exc_w.
- wdata  in  32  — mtc0 data.
- pc_in  in  32  — PC of the faulting instruction.
- hw_irq  in  NUM_HWIRQ  — level interrupt lines, asynchronous to nothing (already in clk domain).
- rdata  out  32  — read data.
- pcreg  out  32  — EPC.
- status  out  32  — Status.
- irq_req  out  1  — interrupt request to control.
- stk_ovf  out  1  — sticky: Status pushed while stack full.
- stk_unf  out  1  — sticky: eret with stack empty.

## Operation
- Registers: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. All other indices read 0 and ignore writes.
- Command priority in one cycle: exc_w > ret_w > we. Lower commands are dropped.
- exc_w:
  - Push the current Status onto the stack.
  - Status ← Status << 5.
  - Cause[6:2] ← cause.
  - EPC ← pc_in.
  - Cause.IP bits are preserved.
- ret_w:
  - Pop: Status ← top entry.
  - If the stack is empty: Status ← STATUS_RST and stk_unf ← 1.
- Stack full on push: discard the oldest entry, push the new one, set stk_ovf. Depth stays STACK_DEPTH.
- mtc0 write effects:
  - Count, Compare, Status, EPC: full 32-bit write.
  - Cause: only IP[1:0] (bits 9:8, software interrupts) are writable.
  - Write to Compare clears IP[7].
  - Write to Count overrides the increment that cycle.
- Count increments by 1 every cycle, wrapping at 2^32−1 → 0.
- Timer: when Count == Compare (registered compare), IP[7] sets on the next edge. It is sticky until Compare is written.
- hw_irq is registered once. Cause.IP[2+i] follows the registered hw_irq[i] (level, not sticky). Unused IP bits in [6:2] read 0.
- irq_req = Status[0] & |(Cause[15:8] & Status[15:8]). Combinational from registered state only.
- rdata = re ? reg[Rd] : 32'h0. No tristate. Same-cycle writes are not bypassed.
- stk_ovf and stk_unf clear only on reset.

## Timing
- On reset:
  - Status = STATUS_RST.
  - Count, Compare, Cause, EPC = 0.
  - Stack empty, stk_ovf = stk_unf = 0, hw_irq sync stage = 0.
  - irq_req = 0 (STATUS_RST & 0 IP).
- Reset wins over all strobes. Reset mid-nest empties the stack.
- exc_w, ret_w and we all take effect at the same edge. The new values are visible on rdata, status and pcreg right after that edge.
- hw_irq to Cause.IP: 1 cycle. Cause.IP to irq_req: 0 cycles.
- Compare match to IP[7]: 1 cycle after the cycle where Count == Compare.
- Compare == 0 with Count wrapping still matches.

## Structure
- Package cp0_pkg:
  - Register index constants (CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14).
  - ExcCode constants (SYSCALL=8, BREAK=9, TEQ=13).
  - Cause field positions.
- Sub-module cp0_status_stack:
  - Parameters: depth and width 32.
  - Inputs: push, pop, din.
  - Outputs: dout, empty, full.
  - Drop-oldest on push-when-full.
  - Circular buffer with a count.

## Test plan
- Reset then read all registers → Status=32'h701, others 0, irq_req=0, flags 0.
- syscall (exc_w, cause=8, pc_in=32'h0040_0010) → Cause=32'h20, EPC=32'h0040_0010, Status=32'hE020; eret → Status=32'h701.
- Three nested exceptions then three erets (depth 4) → Status sequence 701→E020→1C0400→3808000, then unwinds exactly; a 5th push sets stk_ovf and an extra eret sets stk_unf with Status=32'h701.
- Compare=20, Status=32'h8001 → IP[7] sets at Count 21, irq_req=1; mtc0 Compare → IP[7]=0 next cycle.
- hw_irq[0]=1 with Status=32'h0401 → Cause.IP[2]=1 one cycle later, irq_req=1; hw_irq low → clears one cycle later.
- exc_w, ret_w and we in the same cycle → only the exception effects apply, and Wd is not written.
